gaussian_blur_3x3: RTL and testbench
====================================

Name: gaussian_blur_3x3

Overview:
- Stage directly downstream of the colour-to-greyscale converter in the Oriented-FAST ISP chain.
- Raster-scans the 8-bit greyscale SRAM image and applies a 3x3 binomial Gaussian kernel with edge-clamped borders.
- Writes the smoothed image to a separate blur SRAM, which the FAST corner stage reads next.
- Self-sequencing: owns its x/y scan counters and needs no external pixel-position block.

Parameters:
- X_MAX, 400, image width in pixels
- Y_MAX, 400, image height in pixels
- AW_X, $clog2(X_MAX)+1, x address width (derived, not overridden)
- AW_Y, $clog2(Y_MAX)+1, y address width (derived, not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  begin a full-frame pass; sampled only in IDLE
- ren_bw  out  1  greyscale SRAM read strobe
- x_addr_bw  out  AW_X  greyscale read column
- y_addr_bw  out  AW_Y  greyscale read row
- rdat_bw  in  8  greyscale read data, valid the cycle after ren_bw
- wen_blur  out  1  blur SRAM write strobe
- x_addr_blur  out  AW_X  blur write column
- y_addr_blur  out  AW_Y  blur write row
- wdat_blur  out  8  blurred pixel
- busy  out  1  high in every state except IDLE
- blur_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (n_rst low at a clock edge), including mid-frame:
  - State goes to IDLE; scan counters and window registers go to 0.
  - All strobes, addresses, wdat_blur, busy and blur_done read 0 from the next cycle.
  - Any in-flight read is discarded.
- Window: 3x3 register array w[col][row], col 0 = x-1, col 1 = x, col 2 = x+1.
- Clamping: every coordinate is clamped to 0..X_MAX-1 / 0..Y_MAX-1 before it is issued as an address.
- Read capture:
  - Each issued read registers a destination tag (column mask, row).
  - The following cycle, rdat_bw is written to that slot. Preload writes both col 0 and col 1.
- State IDLE: start=1 -> PRELOAD with x=0, y=0. start while busy is ignored.
- State PRELOAD, 3 cycles, r=0..2:
  - Reads (col 0, clamp(y-1+r)); destination w[0][r] and w[1][r].
  - After r=2 -> FETCH.
- State FETCH, 3 cycles, r=0..2:
  - Reads (clamp(x+1), clamp(y-1+r)); destination w[2][r].
  - After r=2 -> LATCH.
- State LATCH, 1 cycle: captures the final read. No strobe.
- State WRITE, 1 cycle:
  - wen_blur=1, address (x, y), wdat_blur = kernel output.
  - Window shifts: col0<=col1, col1<=col2.
  - If x<X_MAX-1: x++ and -> FETCH.
  - Else if y<Y_MAX-1: x=0, y++ and -> PRELOAD.
  - Else -> DONE.
- State DONE, 1 cycle: blur_done=1 -> IDLE.
- Throughput:
  - 5 cycles per pixel, plus 3 per row.
  - Frame latency from start = 1 + Y_MAX*(3+5*X_MAX) + 1 cycles to the blur_done pulse.
- Kernel: weights [1 2 1; 2 4 2; 1 2 1].
  - Sum is 12 bits unsigned, maximum 4080, no overflow.
  - Output = sum>>4 (truncate), range 0..255.
- Addresses and strobes are 0 in any cycle where the strobe is low. ren_bw and wen_blur are never high together.
- Degenerate image X_MAX=1 or Y_MAX=1: clamping alone handles it, no special case.

Optional Feature:
- Macro BLUR_ROUND_EN.
- Defined: output = (sum+8)>>4; sum+8 is computed at 13 bits and saturated to 255.
- Undefined: truncate, sum>>4.
- Timing and interface are identical either way.

Decomposition:
- Shared package isp_pkg holds:
  - blur_state_t enum: IDLE, PRELOAD, FETCH, LATCH, WRITE, DONE
  - Kernel weight constants and KERNEL_SHIFT=4
  - A clamp helper function
- Sub-module blur_kernel_3x3: combinational. Takes 9x8-bit window, produces the 8-bit result; the rounding macro lives here.
- FSM, counters and window registers stay in gaussian_blur_3x3.

Test Plan:
- Flat image: X_MAX=4, Y_MAX=4, all pixels 100, start -> 16 writes, all wdat_blur=100. blur_done exactly at cycle 1+4*23+1=94 after start.
- Impulse: pixel (1,1)=160, rest 0 -> out(1,1)=40, (0,1)=20, (1,0)=20, (0,0)=10, (3,3)=0.
- Rounding: impulse (1,1)=8 -> corner (0,0)=0 without BLUR_ROUND_EN, 1 with it; centre (1,1)=2 both ways.
- Saturation/edges: all pixels 255 -> all outputs 255 in both builds, with no wrap at any corner.
- Reset mid-frame: drop n_rst during the 6th pixel -> next cycle busy=0 and wen_blur=0. A fresh start reproduces the flat-image result bit-exactly.
- Protocol: pulse start while busy -> ignored. The bench asserts ren_bw and wen_blur are never high together, and that every read address stays in range.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared types and constants for the Oriented-FAST ISP stages.
// Holds the blur FSM state type, the binomial kernel weights and a coordinate clamp helper.
package isp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    FETCH,
    LATCH,
    WRITE,
    DONE
  } blur_state_t;

  localparam int W_CORNER     = 1;
  localparam int W_EDGE       = 2;
  localparam int W_CENTRE     = 4;
  localparam int KERNEL_SHIFT = 4;

  // Clamp a signed coordinate into 0..lim-1 (edge replication at the borders).
  function automatic int clamp_coord(input int c, input int lim);
    if (c < 0) return 0;
    if (c > lim - 1) return lim - 1;
    return c;
  endfunction

endpackage

// File: rtl/blur_kernel_3x3.sv
// Combinational 3x3 binomial kernel; window indexed [col][row].
// Define BLUR_ROUND_EN to round to nearest (saturated) instead of truncating.
module blur_kernel_3x3
  import isp_pkg::*;
(
  input  logic [2:0][2:0][7:0] win_i,
  output logic [7:0]           pix_o
);

  logic [9:0]  corners;
  logic [9:0]  edges;
  logic [11:0] sum;

  always_comb begin
    corners = 10'(win_i[0][0]) + 10'(win_i[2][0]) + 10'(win_i[0][2]) + 10'(win_i[2][2]);
    edges   = 10'(win_i[1][0]) + 10'(win_i[0][1]) + 10'(win_i[2][1]) + 10'(win_i[1][2]);
    sum     = 12'(corners) * 12'(W_CORNER)
            + 12'(edges) * 12'(W_EDGE)
            + 12'(win_i[1][1]) * 12'(W_CENTRE);
  end

`ifdef BLUR_ROUND_EN
  logic [12:0] sum_rnd;
  logic [12:0] shifted;

  always_comb begin
    sum_rnd = {1'b0, sum} + 13'd8;
    shifted = sum_rnd >> KERNEL_SHIFT;
    pix_o   = (shifted > 13'd255) ? 8'd255 : 8'(shifted);
  end
`else
  assign pix_o = 8'(sum >> KERNEL_SHIFT);
`endif

endmodule

// File: rtl/gaussian_blur_3x3.sv
// Self-sequencing 3x3 Gaussian blur: raster-scans the greyscale SRAM, writes the blur SRAM.
// States: IDLE wait start | PRELOAD fill cols 0/1 | FETCH read col x+1 | LATCH last capture | WRITE emit+shift | DONE pulse
module gaussian_blur_3x3
  import isp_pkg::*;
#(
  parameter  int X_MAX = 400,
  parameter  int Y_MAX = 400,
  localparam int AW_X  = $clog2(X_MAX) + 1,
  localparam int AW_Y  = $clog2(Y_MAX) + 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start,
  output logic            ren_bw,
  output logic [AW_X-1:0] x_addr_bw,
  output logic [AW_Y-1:0] y_addr_bw,
  input  logic [7:0]      rdat_bw,
  output logic            wen_blur,
  output logic [AW_X-1:0] x_addr_blur,
  output logic [AW_Y-1:0] y_addr_blur,
  output logic [7:0]      wdat_blur,
  output logic            busy,
  output logic            blur_done
);

  blur_state_t          state_q, state_d;
  logic [AW_X-1:0]      x_q, x_d;
  logic [AW_Y-1:0]      y_q, y_d;
  logic [1:0]           r_q, r_d;
  logic [2:0][2:0][7:0] win_q;
  logic                 tag_v_q;
  logic [2:0]           tag_mask_q;
  logic [1:0]           tag_row_q;

  logic                 issue_v;
  logic [2:0]           issue_mask;
  logic                 shift;
  logic [AW_Y-1:0]      row_addr;
  logic [AW_X-1:0]      col_next;
  logic [7:0]           kern_pix;

  assign row_addr = AW_Y'(clamp_coord(int'(y_q) + int'(r_q) - 1, Y_MAX));
  assign col_next = AW_X'(clamp_coord(int'(x_q) + 1, X_MAX));

  blur_kernel_3x3 u_kernel (
    .win_i (win_q),
    .pix_o (kern_pix)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    r_d         = r_q;
    ren_bw      = 1'b0;
    x_addr_bw   = '0;
    y_addr_bw   = '0;
    wen_blur    = 1'b0;
    x_addr_blur = '0;
    y_addr_blur = '0;
    wdat_blur   = '0;
    blur_done   = 1'b0;
    busy        = (state_q != IDLE);
    issue_v     = 1'b0;
    issue_mask  = '0;
    shift       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRELOAD;
          x_d     = '0;
          y_d     = '0;
          r_d     = '0;
        end
      end
      PRELOAD: begin
        ren_bw     = 1'b1;
        y_addr_bw  = row_addr;
        issue_v    = 1'b1;
        issue_mask = 3'b011;
        if (r_q == 2'd2) begin
          r_d     = '0;
          state_d = FETCH;
        end else begin
          r_d = 2'(r_q + 2'd1);
        end
      end
      FETCH: begin
        ren_bw     = 1'b1;
        x_addr_bw  = col_next;
        y_addr_bw  = row_addr;
        issue_v    = 1'b1;
        issue_mask = 3'b100;
        if (r_q == 2'd2) begin
          r_d     = '0;
          state_d = LATCH;
        end else begin
          r_d = 2'(r_q + 2'd1);
        end
      end
      LATCH: state_d = WRITE;
      WRITE: begin
        wen_blur    = 1'b1;
        x_addr_blur = x_q;
        y_addr_blur = y_q;
        wdat_blur   = kern_pix;
        shift       = 1'b1;
        if (x_q < AW_X'(X_MAX - 1)) begin
          x_d     = AW_X'(x_q + 1'b1);
          state_d = FETCH;
        end else if (y_q < AW_Y'(Y_MAX - 1)) begin
          x_d     = '0;
          y_d     = AW_Y'(y_q + 1'b1);
          state_d = PRELOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        blur_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture lands one cycle after its read; never coincides with the WRITE shift.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      win_q      <= '0;
      tag_v_q    <= 1'b0;
      tag_mask_q <= '0;
      tag_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      r_q        <= r_d;
      tag_v_q    <= issue_v;
      tag_mask_q <= issue_mask;
      tag_row_q  <= r_q;
      if (shift) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
      end else if (tag_v_q) begin
        for (int c = 0; c < 3; c++) begin
          if (tag_mask_q[c]) win_q[c][tag_row_q] <= rdat_bw;
        end
      end
    end
  end

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Self-checking bench for gaussian_blur_3x3 on a 4x4 image with SRAM models and a reference blur.
module tb_gaussian_blur_3x3;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int AX = $clog2(X) + 1;
  localparam int AY = $clog2(Y) + 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          ren_bw;
  logic [AX-1:0] x_addr_bw;
  logic [AY-1:0] y_addr_bw;
  logic [7:0]    rdat_bw;
  logic          wen_blur;
  logic [AX-1:0] x_addr_blur;
  logic [AY-1:0] y_addr_blur;
  logic [7:0]    wdat_blur;
  logic          busy;
  logic          blur_done;

  int n_vec = 0;
  int n_err = 0;
  int img     [Y][X];
  int out_img [Y][X];
  int wr_cnt;

  gaussian_blur_3x3 #(.X_MAX(X), .Y_MAX(Y)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .ren_bw      (ren_bw),
    .x_addr_bw   (x_addr_bw),
    .y_addr_bw   (y_addr_bw),
    .rdat_bw     (rdat_bw),
    .wen_blur    (wen_blur),
    .x_addr_blur (x_addr_blur),
    .y_addr_blur (y_addr_blur),
    .wdat_blur   (wdat_blur),
    .busy        (busy),
    .blur_done   (blur_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int c, input int lim);
    return (c < 0) ? 0 : ((c > lim - 1) ? lim - 1 : c);
  endfunction

  function automatic int ref_pix(input int x, input int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1) * img[clampi(y + dy, Y)][clampi(x + dx, X)];
`ifdef BLUR_ROUND_EN
    return ((s + 8) / 16 > 255) ? 255 : (s + 8) / 16;
`else
    return s / 16;
`endif
  endfunction

  // Greyscale SRAM model plus protocol and write-port monitor.
  initial begin
    int nxt;
    rdat_bw = 8'd0;
    forever begin
      @(negedge clk);
      nxt = $urandom_range(0, 255);
      if (busy) chk("rd_wr_excl", int'(ren_bw & wen_blur), 0);
      if (ren_bw) begin
        chk("rd_x_range", int'(x_addr_bw < AX'(X)), 1);
        chk("rd_y_range", int'(y_addr_bw < AY'(Y)), 1);
        if (x_addr_bw < AX'(X) && y_addr_bw < AY'(Y)) nxt = img[y_addr_bw][x_addr_bw];
      end else if (busy) begin
        chk("rd_addr_idle", int'(x_addr_bw) + int'(y_addr_bw), 0);
      end
      if (wen_blur) begin
        chk("wr_x_order", int'(x_addr_blur), wr_cnt % X);
        chk("wr_y_order", int'(y_addr_blur), wr_cnt / X);
        if (x_addr_blur < AX'(X) && y_addr_blur < AY'(Y)) out_img[y_addr_blur][x_addr_blur] = int'(wdat_blur);
        wr_cnt++;
      end else if (busy) begin
        chk("wr_idle_zero", int'(x_addr_blur) + int'(y_addr_blur) + int'(wdat_blur), 0);
      end
      @(posedge clk);
      #1 rdat_bw = 8'(nxt);
    end
  end

  task automatic fill(input int mode, input int v);
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++)
        img[y][x] = (mode == 0) ? v : ((mode == 1) ? ((x == 1 && y == 1) ? v : 0) : $urandom_range(0, 255));
  endtask

  task automatic run_frame(input string name, input bit poke_start);
    int cyc;
    bit seen;
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) out_img[y][x] = -1;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    cyc   = 1;
    seen  = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (poke_start) start = (cyc == 40);
      if (blur_done) seen = 1'b1;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_latency"}, cyc, 1 + Y * (3 + 5 * X) + 1);
    chk({name, "_wr_cnt"}, wr_cnt, X * Y);
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) chk({name, "_pix"}, out_img[y][x], ref_pix(x, y));
    @(negedge clk);
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_done_pulse"}, int'(blur_done), 0);
  endtask

  initial begin
    int guard;
    n_rst  = 1'b0;
    start  = 1'b0;
    wr_cnt = 0;
    fill(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ren", int'(ren_bw), 0);
    chk("rst_wen", int'(wen_blur), 0);
    chk("rst_done", int'(blur_done), 0);
    chk("rst_wdat", int'(wdat_blur), 0);
    n_rst = 1'b1;

    fill(0, 100);
    run_frame("flat", 1'b0);
    chk("flat_corner", out_img[0][0], 100);

    fill(1, 160);
    run_frame("imp160", 1'b0);
    chk("imp_c", out_img[1][1], 40);
    chk("imp_w", out_img[1][0], 20);
    chk("imp_n", out_img[0][1], 20);
    chk("imp_nw", out_img[0][0], 10);
    chk("imp_far", out_img[3][3], 0);

    fill(1, 8);
    run_frame("imp8", 1'b0);
    chk("rnd_centre", out_img[1][1], 2);
`ifdef BLUR_ROUND_EN
    chk("rnd_corner", out_img[0][0], 1);
`else
    chk("rnd_corner", out_img[0][0], 0);
`endif

    fill(0, 255);
    run_frame("sat", 1'b0);
    chk("sat_00", out_img[0][0], 255);
    chk("sat_33", out_img[3][3], 255);

    for (int i = 0; i < 3; i++) begin
      fill(2, 0);
      run_frame("rand", 1'b0);
    end

    fill(2, 0);
    run_frame("busy_start", 1'b1);

    // Drop reset while the sixth pixel is being fetched.
    fill(0, 100);
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (wr_cnt < 5 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_reached", int'(wr_cnt >= 5), 1);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_wen", int'(wen_blur), 0);
    chk("mid_ren", int'(ren_bw), 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_frame("after_rst", 1'b0);
    chk("after_rst_00", out_img[0][0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
